bdi_compressor: RTL and testbench

//  Base-Delta-Immediate compressor for 256-bit lines; sits directly upstream of the

---
 rtl/bdi_compressor.sv | 159 +++++++++++++++
 tb/tb_bdi_compressor.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bdi_compressor.sv
// rtl/bdi_compressor.sv - Base-Delta-Immediate line compressor (256-bit), valid/ready both sides.
// Define CMP_PARALLEL_EN to evaluate all candidates in one cycle instead of a serial scan.
module bdi_compressor #(
   parameter logic [6:0] CAND_EN  = 7'h7F,
   parameter logic [3:0] RAW_CODE = 4'd15
) (
   input  logic         clock,
   input  logic         rst,
   input  logic [255:0] i_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [255:0] o_data,
   output logic [3:0]   encoding,
   output logic [5:0]   o_size,
   output logic         out_valid,
   input  logic         out_ready
);

   typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

   typedef struct packed {
      logic         hit;
      logic [3:0]   code;
      logic [5:0]   size;
      logic [255:0] data;
   } res_t;

   state_t       state;
   logic [255:0] line_q;
   res_t         raw_res;
   res_t         res;
   logic         done;

   // Base is word 0; delta slot 0 stays zero so the decompressor can index slots uniformly.
   function automatic res_t bd(input logic [255:0] line, input int w, input int d,
                               input logic [3:0] code, input logic [5:0] size);
      res_t        r;
      logic [63:0] mask;
      logic [63:0] base;
      logic [63:0] wi;
      logic [63:0] diff;
      int          n;
      mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      base   = line[63:0] & mask;
      n      = 256 / w;
      r.hit  = 1'b1;
      r.code = code;
      r.size = size;
      r.data = 256'(base);
      for (int i = 1; i < 16; i++) begin
         if (i < n) begin
            wi   = 64'(line >> (i * w)) & mask;
            diff = (base - wi) & mask;
            if ((diff >> d) != 64'd0) r.hit = 1'b0;
            r.data = r.data | (256'(diff) << (w + i * d));
         end
      end
      return r;
   endfunction

   function automatic res_t eval_cand(input logic [255:0] line, input logic [2:0] k);
      res_t       r;
      logic [7:0] en;
      en = {1'b0, CAND_EN};
      r  = '0;
      case (k)
         3'd0:    r.hit = (line == '0);
         3'd1:    r = bd(line, 64, 8,  4'd2, 6'd12);
         3'd2:    r = bd(line, 32, 8,  4'd6, 6'd12);
         3'd3:    r = bd(line, 64, 16, 4'd4, 6'd16);
         3'd4:    r = bd(line, 16, 8,  4'd7, 6'd18);
         3'd5:    r = bd(line, 32, 16, 4'd5, 6'd20);
         3'd6:    r = bd(line, 64, 32, 4'd3, 6'd24);
         default: r = '0;
      endcase
      r.hit = r.hit & en[k];
      return r;
   endfunction

   always_comb begin
      raw_res      = '0;
      raw_res.hit  = 1'b1;
      raw_res.code = RAW_CODE;
      raw_res.size = 6'd32;
      raw_res.data = line_q;
   end

`ifdef CMP_PARALLEL_EN
   res_t cand_r;

   // Walk from lowest priority up so the earliest hit in scan order wins.
   always_comb begin
      res    = raw_res;
      cand_r = '0;
      for (int k = 6; k >= 0; k--) begin
         cand_r = eval_cand(line_q, 3'(k));
         if (cand_r.hit) res = cand_r;
      end
      done = 1'b1;
   end
`else
   logic [2:0] idx;
   res_t       cur;

   always_comb begin
      cur  = eval_cand(line_q, idx);
      res  = cur.hit ? cur : raw_res;
      done = cur.hit || (idx == 3'd6);
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst)
         idx <= 3'd0;
      else if (state == IDLE)
         idx <= 3'd0;
      else if (state == SCAN && !done)
         idx <= idx + 3'd1;
   end
`endif

   assign in_ready = (state == IDLE) && !rst;

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         line_q    <= '0;
         o_data    <= '0;
         encoding  <= 4'd0;
         o_size    <= 6'd0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  line_q <= i_data;
                  state  <= SCAN;
               end
            end
            SCAN: begin
               if (done) begin
                  o_data    <= res.data;
                  encoding  <= res.code;
                  o_size    <= res.size;
                  out_valid <= 1'b1;
                  state     <= OUT;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bdi_compressor.sv
// tb/tb_bdi_compressor.sv - self-checking bench for bdi_compressor against a bit-level reference model.
module tb_bdi_compressor;

   logic         clock = 1'b0;
   logic         rst = 1'b1;
   logic [255:0] i_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [255:0] o_data;
   logic [3:0]   encoding;
   logic [5:0]   o_size;
   logic         out_valid;
   logic         out_ready = 1'b1;

   int total = 0;
   int bad = 0;

   int cw[7]    = '{0, 64, 32, 64, 16, 32, 64};
   int cd[7]    = '{0, 8, 8, 16, 8, 16, 32};
   int ccode[7] = '{0, 2, 6, 4, 7, 5, 3};
   int csize[7] = '{0, 12, 12, 16, 18, 20, 24};

   bdi_compressor dut (
      .clock(clock), .rst(rst), .i_data(i_data), .in_valid(in_valid), .in_ready(in_ready),
      .o_data(o_data), .encoding(encoding), .o_size(o_size), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit fits(input logic [255:0] l, input int k, output logic [255:0] d);
      longint unsigned base, w, diff;
      int W, D, n;
      bit ok;
      W = cw[k]; D = cd[k]; n = 256 / W;
      base = 0; d = '0; ok = 1;
      for (int b = 0; b < W; b++) begin
         base[b] = l[b];
         d[b]    = l[b];
      end
      for (int i = 1; i < n; i++) begin
         w = 0;
         for (int b = 0; b < W; b++) w[b] = l[i * W + b];
         diff = base - w;
         if (W < 64) diff = diff % (64'd1 << W);
         if (diff >= (64'd1 << D)) ok = 0;
         for (int b = 0; b < D; b++) d[W + i * D + b] = diff[b];
      end
      return ok;
   endfunction

   task automatic model(input logic [255:0] l, output logic [3:0] c, output logic [255:0] d,
                        output logic [5:0] s, output int lat);
      logic [255:0] pk;
      bit found;
      found = 0;
      c = 4'd15; d = l; s = 6'd32; lat = 7;
      if (l == '0) begin
         c = 4'd0; d = '0; s = 6'd0; lat = 1; found = 1;
      end
      for (int k = 1; k < 7; k++) begin
         if (!found && fits(l, k, pk)) begin
            c = 4'(ccode[k]); d = pk; s = 6'(csize[k]); lat = k + 1; found = 1;
         end
      end
`ifdef CMP_PARALLEL_EN
      lat = 1;
`endif
   endtask

   function automatic logic [255:0] make_line(input int k);
      longint unsigned mw, md, base, dl, w;
      logic [255:0] l;
      int n;
      mw = (cw[k] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << cw[k]) - 64'd1);
      md = (64'd1 << cd[k]) - 64'd1;
      base = {$urandom, $urandom} & mw;
      n = 256 / cw[k];
      l = '0;
      for (int i = 0; i < n; i++) begin
         dl = (i == 0) ? 64'd0 : ({$urandom, $urandom} & md);
         w = (base - dl) & mw;
         for (int b = 0; b < cw[k]; b++) l[i * cw[k] + b] = w[b];
      end
      return l;
   endfunction

   task automatic run_line(input logic [255:0] l, input string tag, output int lat);
      int n;
      n = 0;
      @(negedge clock);
      while (!in_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      chk({tag, " in_ready"}, 256'(in_ready), 256'(1));
      i_data = l;
      in_valid = 1'b1;
      @(posedge clock);
      #1 in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clock);
         #1;
         lat++;
      end
   endtask

   task automatic full_check(input logic [255:0] l, input string tag, input logic [3:0] ec,
                             input logic [255:0] ed, input logic [5:0] es, input int elat);
      int lat;
      run_line(l, tag, lat);
      chk({tag, " latency"}, 256'(lat), 256'(elat));
      chk({tag, " encoding"}, 256'(encoding), 256'(ec));
      chk({tag, " o_data"}, o_data, ed);
      chk({tag, " o_size"}, 256'(o_size), 256'(es));
      @(posedge clock);
      #1;
      chk({tag, " handoff out_valid"}, 256'(out_valid), 256'(0));
      chk({tag, " handoff in_ready"}, 256'(in_ready), 256'(1));
   endtask

   initial begin
      logic [255:0] l2, l3, l4, e2, e3, l, ed, snap;
      logic [3:0] ec;
      logic [5:0] es;
      int elat, lat, k;

      // reset state
      #1;
      chk("rst in_ready", 256'(in_ready), 256'(0));
      chk("rst out_valid", 256'(out_valid), 256'(0));
      chk("rst encoding", 256'(encoding), 256'(0));
      chk("rst o_size", 256'(o_size), 256'(0));
      chk("rst o_data", o_data, '0);
      @(posedge clock);
      @(negedge clock);
      rst = 1'b0;

      // T1 zero line
      full_check('0, "t1", 4'd0, '0, 6'd0, 1);

      // T2 B8D1
      l2 = {64'hF01, 64'hFF0, 64'hFFF, 64'h1000};
      e2 = {160'd0, 8'hFF, 8'h10, 8'h01, 8'h00, 64'h1000};
`ifdef CMP_PARALLEL_EN
      elat = 1;
`else
      elat = 2;
`endif
      full_check(l2, "t2", 4'd2, e2, 6'd12, elat);

      // T3 B4D2
      l3 = '0;
      e3 = '0;
      for (int i = 0; i < 8; i++) l3[i * 32 +: 32] = 32'h00012345 - 32'h100 * i;
      e3[31:0] = 32'h00012345;
      for (int i = 1; i < 8; i++) e3[32 + 16 * i +: 16] = 16'(32'h100 * i);
`ifdef CMP_PARALLEL_EN
      elat = 1;
`else
      elat = 6;
`endif
      full_check(l3, "t3", 4'd5, e3, 6'd20, elat);

      // T4 raw
      for (int i = 0; i < 32; i++) l4[i * 8 +: 8] = 8'(i + 1);
`ifdef CMP_PARALLEL_EN
      elat = 1;
`else
      elat = 7;
`endif
      full_check(l4, "t4", 4'd15, l4, 6'd32, elat);

      // T5 backpressure
      out_ready = 1'b0;
      run_line(l2, "t5", lat);
      chk("t5 out_valid", 256'(out_valid), 256'(1));
      snap = o_data;
      chk("t5 o_data", snap, e2);
      for (int c = 0; c < 5; c++) begin
         i_data = ~l2;
         in_valid = 1'b1;
         @(posedge clock);
         #1;
         chk("t5 hold out_valid", 256'(out_valid), 256'(1));
         chk("t5 hold o_data", o_data, e2);
         chk("t5 hold encoding", 256'(encoding), 256'(2));
         chk("t5 hold o_size", 256'(o_size), 256'(12));
         chk("t5 hold in_ready", 256'(in_ready), 256'(0));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      chk("t5 handoff out_valid", 256'(out_valid), 256'(0));
      chk("t5 handoff in_ready", 256'(in_ready), 256'(1));
      @(posedge clock);
      #1;
      chk("t5 no stray accept", 256'(in_ready), 256'(1));

      // T6 reset mid-scan
      @(negedge clock);
      i_data = l4;
      in_valid = 1'b1;
      @(posedge clock);
      #1 in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("t6 out_valid", 256'(out_valid), 256'(0));
      chk("t6 in_ready", 256'(in_ready), 256'(0));
      chk("t6 encoding", 256'(encoding), 256'(0));
      @(posedge clock);
      @(negedge clock);
      rst = 1'b0;
      #1;
      chk("t6 post in_ready", 256'(in_ready), 256'(1));
      full_check('0, "t6 t1", 4'd0, '0, 6'd0, 1);

      // randomized structured lines checked against the model
      for (int r = 0; r < 24; r++) begin
         k = $urandom_range(0, 6);
         l = (k == 0) ? '0 : make_line(k);
         if ($urandom_range(0, 3) == 0) l[$urandom_range(0, 255)] ^= 1'b1;
         model(l, ec, ed, es, elat);
         full_check(l, $sformatf("rnd%0d", r), ec, ed, es, elat);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
